// File: rtl/parity_pkg.sv
// Shared types and constants for the parity serial receiver slice.
// Latency: n/a (declarations only). Backpressure: n/a.
// Error-count width is used only when PARITY_RX_ERR_COUNT_EN is defined.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/parity_serial_rx_if.sv
// Output word handshake between the serial receiver and its consumer.
// Latency: n/a (wiring only). Backpressure: consumer holds out_ready low to stall.
// master = receiver side, slave = consumer side.
interface parity_serial_rx_if #(
    parameter int DATA_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_parity;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (
        output out_valid, out_data, out_parity, parity_err, frame_err, overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_parity, parity_err, frame_err, overrun,
        output out_ready
    );
endinterface

// File: rtl/parity_rx_outbuf.sv
// One-entry holding register for received words, with overrun pulse on drop.
// Latency: word visible the cycle after frame_vld. Backpressure: drops new frame when full and not draining.
module parity_rx_outbuf #(
    parameter int DATA_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_vld,
    input  logic [DATA_W-1:0]    frame_dat,
    input  logic                 frame_par,
    input  logic                 frame_perr,
    input  logic                 frame_ferr,
    parity_serial_rx_if.master   bus
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              load;

    // A slot frees up in the same cycle the current word is accepted.
    assign load = frame_vld && (!valid_q || bus.out_ready);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = frame_vld && !load;
        if (load) begin
            valid_d = 1'b1;
            data_d  = frame_dat;
            par_d   = frame_par;
            perr_d  = frame_perr;
            ferr_d  = frame_ferr;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.out_parity = par_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: rtl/parity_serial_rx.sv
// Bit-serial frame receiver (start, DATA_W data LSB first, parity, stop) feeding a one-word output buffer.
// Latency: out_valid rises the cycle after the stop-bit sample. Backpressure: buffer full drops frame, pulses overrun.
// Optional PARITY_RX_ERR_COUNT_EN adds a saturating error counter (err_clr / err_count).
module parity_serial_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_en,
    input  logic                  rx_in,
`ifdef PARITY_RX_ERR_COUNT_EN
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count,
`endif
    parity_serial_rx_if.master    bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              frame_vld;
    logic              frame_perr;
    logic              frame_ferr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        frame_vld = 1'b0;
        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_in == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    // New bit enters at the MSB so the first bit ends up as the LSB.
                    shift_d         = shift_q >> 1;
                    shift_d[DATA_W-1] = rx_in;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    par_d   = rx_in;
                    state_d = STOP;
                end
                STOP: begin
                    frame_vld = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign frame_perr = (^shift_q) ^ par_q ^ PARITY_ODD;
    assign frame_ferr = (rx_in != STOP_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    parity_rx_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk        (clk),
        .rst        (rst),
        .frame_vld  (frame_vld),
        .frame_dat  (shift_q),
        .frame_par  (par_q),
        .frame_perr (frame_perr),
        .frame_ferr (frame_ferr),
        .bus        (bus)
    );

`ifdef PARITY_RX_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 err_inc;

    // A completed frame either loads (count its error flags) or is dropped (count the overrun).
    assign err_inc = frame_vld &&
                     (frame_perr || frame_ferr || (bus.out_valid && !bus.out_ready));

    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx (DATA_W=4, even parity); inputs driven on negedge, outputs sampled on negedge.
// Error-counter checks are compiled in only when PARITY_RX_ERR_COUNT_EN is defined.
module tb_parity_serial_rx;

    logic clk;
    logic rst;
    logic bit_en;
    logic rx_in;
`ifdef PARITY_RX_ERR_COUNT_EN
    logic       err_clr;
    logic [7:0] err_count;
`endif

    int n_checks;
    int n_fail;

    parity_serial_rx_if #(.DATA_W(4)) rx_bus ();

    parity_serial_rx #(
        .DATA_W     (4),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .rx_in     (rx_in),
`ifdef PARITY_RX_ERR_COUNT_EN
        .err_clr   (err_clr),
        .err_count (err_count),
`endif
        .bus       (rx_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_en = 1'b1;
        rx_in  = b;
        @(negedge clk);
        bit_en = 1'b0;
        rx_in  = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1; rx_bus.out_ready = 1'b0;
`ifdef PARITY_RX_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_bus.out_valid); end
        n_checks++; if (rx_bus.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rx_bus.out_data); end
        n_checks++; if (rx_bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", rx_bus.out_parity); end
        n_checks++; if (rx_bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", rx_bus.parity_err); end
        n_checks++; if (rx_bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", rx_bus.frame_err); end
        n_checks++; if (rx_bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", rx_bus.overrun); end
`ifdef PARITY_RX_ERR_COUNT_EN
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_basic();
        rx_bus.out_ready = 1'b1;
        send_frame(4'b1011, 1'b1, 1'b1);
        n_checks++; if (rx_bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", rx_bus.out_valid); end
        n_checks++; if (rx_bus.out_data !== 4'b1011) begin n_fail++; $display("FAIL basic_data: got %b want 1011", rx_bus.out_data); end
        n_checks++; if (rx_bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL basic_parity: got %b want 1", rx_bus.out_parity); end
        n_checks++; if (rx_bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", rx_bus.parity_err); end
        n_checks++; if (rx_bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", rx_bus.frame_err); end
        @(negedge clk);
        n_checks++; if (rx_bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", rx_bus.out_valid); end
    endtask

    task automatic test_parity_err();
        rx_bus.out_ready = 1'b1;
        send_frame(4'b1011, 1'b0, 1'b1);
        n_checks++; if (rx_bus.parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b want 1", rx_bus.parity_err); end
        n_checks++; if (rx_bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL perr_parity: got %b want 0", rx_bus.out_parity); end
`ifdef PARITY_RX_ERR_COUNT_EN
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL perr_errcnt: got %0d want 1", err_count); end
`endif
    endtask

    task automatic test_frame_err_back_to_back();
        rx_bus.out_ready = 1'b1;
        send_frame(4'b1011, 1'b1, 1'b0);
        n_checks++; if (rx_bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_valid: got %b want 1", rx_bus.out_valid); end
        n_checks++; if (rx_bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", rx_bus.frame_err); end
        n_checks++; if (rx_bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL ferr_perr: got %b want 0", rx_bus.parity_err); end
        send_frame(4'h5, 1'b0, 1'b1);
        n_checks++; if (rx_bus.out_data !== 4'h5) begin n_fail++; $display("FAIL b2b_data: got %h want 5", rx_bus.out_data); end
        n_checks++; if (rx_bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL b2b_ferr: got %b want 0", rx_bus.frame_err); end
        n_checks++; if (rx_bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rx_bus.out_valid); end
`ifdef PARITY_RX_ERR_COUNT_EN
        n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL ferr_errcnt: got %0d want 2", err_count); end
`endif
    endtask

    task automatic test_overrun();
        @(negedge clk);
        rx_bus.out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1);
        n_checks++; if (rx_bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b want 1", rx_bus.out_valid); end
        n_checks++; if (rx_bus.out_data !== 4'h3) begin n_fail++; $display("FAIL ovr_first_data: got %h want 3", rx_bus.out_data); end
        send_frame(4'hC, 1'b0, 1'b1);
        n_checks++; if (rx_bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", rx_bus.overrun); end
        n_checks++; if (rx_bus.out_data !== 4'h3) begin n_fail++; $display("FAIL ovr_hold_data: got %h want 3", rx_bus.out_data); end
        @(negedge clk);
        n_checks++; if (rx_bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_end: got %b want 0", rx_bus.overrun); end
        n_checks++; if (rx_bus.out_data !== 4'h3) begin n_fail++; $display("FAIL ovr_stable_data: got %h want 3", rx_bus.out_data); end
`ifdef PARITY_RX_ERR_COUNT_EN
        n_checks++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL ovr_errcnt: got %0d want 3", err_count); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL errclr: got %0d want 0", err_count); end
`endif
        rx_bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rx_bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %b want 0", rx_bus.out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        rx_bus.out_ready = 1'b0;
        send_frame(4'hA, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (rx_bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rx_bus.out_valid); end
        rst = 1'b0;
        rx_bus.out_ready = 1'b1;
        send_frame(4'h5, 1'b0, 1'b1);
        n_checks++; if (rx_bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid2: got %b want 1", rx_bus.out_valid); end
        n_checks++; if (rx_bus.out_data !== 4'h5) begin n_fail++; $display("FAIL rstmid_data: got %h want 5", rx_bus.out_data); end
        n_checks++; if (rx_bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_perr: got %b want 0", rx_bus.parity_err); end
        n_checks++; if (rx_bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr: got %b want 0", rx_bus.frame_err); end
    endtask

    task automatic test_stall();
        rx_bus.out_ready = 1'b1;
        @(negedge clk);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 10; i++) begin
            rx_in = i[0];
            @(negedge clk);
        end
        rx_in = 1'b1;
        n_checks++; if (rx_bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid: got %b want 0", rx_bus.out_valid); end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        n_checks++; if (rx_bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_done_valid: got %b want 1", rx_bus.out_valid); end
        n_checks++; if (rx_bus.out_data !== 4'h6) begin n_fail++; $display("FAIL stall_data: got %h want 6", rx_bus.out_data); end
        n_checks++; if (rx_bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL stall_perr: got %b want 0", rx_bus.parity_err); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
